// File: rtl/armleocpu_multiplier_if.sv
`default_nettype none
// ============================================================================
// Module      : armleocpu_multiplier_if
// Description : Request/response bundle for the shift-add multiplier.
//               Ports carried:
//                 fetch   - start request (master -> slave)
//                 op      - 2-bit operation select (master -> slave)
//                 factor0 - 32-bit first operand (master -> slave)
//                 factor1 - 32-bit second operand (master -> slave)
//                 ready   - one-cycle completion pulse (slave -> master)
//                 result  - 32-bit selected result word (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface armleocpu_multiplier_if;
  logic        fetch;
  logic [1:0]  op;
  logic [31:0] factor0;
  logic [31:0] factor1;
  logic        ready;
  logic [31:0] result;

  modport master (
    output fetch,
    output op,
    output factor0,
    output factor1,
    input  ready,
    input  result
  );

  modport slave (
    input  fetch,
    input  op,
    input  factor0,
    input  factor1,
    output ready,
    output result
  );
endinterface
`default_nettype wire

// File: rtl/armleocpu_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : armleocpu_multiplier
// Description : Sequential 32x32 multiplier, one shift-add step per cycle,
//               supporting MUL / MULH / MULHSU / MULHU. Sign handling is done
//               on magnitudes: operands are made non-negative on acceptance
//               and the 64-bit product is negated afterwards if needed.
//               Latency is fixed (data-independent): ready pulses in the
//               cycle following the 33rd rising edge after acceptance.
// Ports       : clk   - clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - slave side of armleocpu_multiplier_if
//                       (fetch, op, factor0, factor1 in; ready, result out)
// Revision    : 1.0 - initial release
// ============================================================================
module armleocpu_multiplier (
  input  wire                          clk,
  input  wire                          rst_n,
  armleocpu_multiplier_if.slave        bus
);

  localparam logic [1:0] C_OP_MUL    = 2'b00;
  localparam logic [1:0] C_OP_MULH   = 2'b01;
  localparam logic [1:0] C_OP_MULHSU = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [1:0]  r_op;
  logic [63:0] r_multiplicand;
  logic [31:0] r_multiplier;
  logic        r_sign;
  logic [63:0] r_acc;
  logic [4:0]  r_cnt;
  logic        r_ready;
  logic [31:0] r_result;

  state_t      w_state_next;
  logic [1:0]  w_op_next;
  logic [63:0] w_multiplicand_next;
  logic [31:0] w_multiplier_next;
  logic        w_sign_next;
  logic [63:0] w_acc_next;
  logic [4:0]  w_cnt_next;
  logic        w_ready_next;
  logic [31:0] w_result_next;

  logic        w_f0_signed;
  logic        w_f1_signed;
  logic        w_f0_neg;
  logic        w_f1_neg;
  logic [31:0] w_mag0;
  logic [31:0] w_mag1;
  logic [63:0] w_product;

  // Operand interpretation for the op presented at acceptance time.
  assign w_f0_signed = (bus.op == C_OP_MULH) || (bus.op == C_OP_MULHSU);
  assign w_f1_signed = (bus.op == C_OP_MULH);
  assign w_f0_neg    = w_f0_signed && bus.factor0[31];
  assign w_f1_neg    = w_f1_signed && bus.factor1[31];

  // 32-bit negation of 0x80000000 gives 0x80000000, which read as unsigned
  // is exactly the required magnitude 2^31.
  assign w_mag0 = w_f0_neg ? (~bus.factor0 + 32'd1) : bus.factor0;
  assign w_mag1 = w_f1_neg ? (~bus.factor1 + 32'd1) : bus.factor1;

  // Signed product recovered from the unsigned magnitude product.
  assign w_product = r_sign ? (~r_acc + 64'd1) : r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_op           <= 2'b00;
      r_multiplicand <= 64'd0;
      r_multiplier   <= 32'd0;
      r_sign         <= 1'b0;
      r_acc          <= 64'd0;
      r_cnt          <= 5'd0;
      r_ready        <= 1'b0;
      r_result       <= 32'd0;
    end else begin
      r_state        <= w_state_next;
      r_op           <= w_op_next;
      r_multiplicand <= w_multiplicand_next;
      r_multiplier   <= w_multiplier_next;
      r_sign         <= w_sign_next;
      r_acc          <= w_acc_next;
      r_cnt          <= w_cnt_next;
      r_ready        <= w_ready_next;
      r_result       <= w_result_next;
    end
  end

  always_comb begin
    w_state_next        = r_state;
    w_op_next           = r_op;
    w_multiplicand_next = r_multiplicand;
    w_multiplier_next   = r_multiplier;
    w_sign_next         = r_sign;
    w_acc_next          = r_acc;
    w_cnt_next          = r_cnt;
    w_ready_next        = 1'b0;
    w_result_next       = r_result;

    case (r_state)
      S_IDLE: begin
        if (bus.fetch) begin
          w_op_next           = bus.op;
          w_multiplicand_next = {32'd0, w_mag0};
          w_multiplier_next   = w_mag1;
          w_sign_next         = w_f0_neg ^ w_f1_neg;
          w_acc_next          = 64'd0;
          w_cnt_next          = 5'd0;
          w_state_next        = S_BUSY;
        end
      end

      S_BUSY: begin
        // One step per cycle regardless of operand values, so latency never
        // depends on data (no early exit on a zero multiplier).
        if (r_multiplier[0]) begin
          w_acc_next = r_acc + r_multiplicand;
        end
        w_multiplicand_next = {r_multiplicand[62:0], 1'b0};
        w_multiplier_next   = {1'b0, r_multiplier[31:1]};
        // Counter wraps 31 -> 0 naturally through the 5-bit increment.
        w_cnt_next          = r_cnt + 5'd1;
        if (r_cnt == 5'd31) begin
          w_state_next = S_DONE;
        end
      end

      S_DONE: begin
        w_result_next = (r_op == C_OP_MUL) ? w_product[31:0] : w_product[63:32];
        w_ready_next  = 1'b1;
        w_state_next  = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign bus.ready  = r_ready;
  assign bus.result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_armleocpu_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_armleocpu_multiplier
// Description : Directed self-checking bench for armleocpu_multiplier.
//               Each scenario task drives its stimulus and compares the
//               observed ready timing and result words against hand-computed
//               values.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_armleocpu_multiplier;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

  armleocpu_multiplier_if bus ();

  armleocpu_multiplier dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request from IDLE, perturb inputs after acceptance, then check
  // latency (33 edges), result, ready deassertion and result hold.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input string name);
    int lat;
    @(negedge clk);
    bus.fetch   = 1'b1;
    bus.op      = op;
    bus.factor0 = a;
    bus.factor1 = b;
    @(posedge clk);
    #1;
    bus.fetch   = 1'b0;
    bus.op      = ~op;
    bus.factor0 = ~a;
    bus.factor1 = b ^ 32'h5A5A_5A5A;
    lat = 0;
    while (!bus.ready && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    compared++;
    if (lat !== 33) begin
      mismatched++;
      $display("FAIL %s latency: got %0d edges, expected 33", name, lat);
    end
    compared++;
    if (bus.result !== exp) begin
      mismatched++;
      $display("FAIL %s result: got %h, expected %h", name, bus.result, exp);
    end
    @(posedge clk);
    #1;
    compared++;
    if (bus.ready !== 1'b0) begin
      mismatched++;
      $display("FAIL %s ready_pulse_width: got %b, expected 0", name, bus.ready);
    end
    compared++;
    if (bus.result !== exp) begin
      mismatched++;
      $display("FAIL %s result_hold: got %h, expected %h", name, bus.result, exp);
    end
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    bus.fetch   = 1'b0;
    bus.op      = 2'b00;
    bus.factor0 = 32'd0;
    bus.factor1 = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    compared++;
    if (bus.ready !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_ready: got %b, expected 0", bus.ready);
    end
    compared++;
    if (bus.result !== 32'd0) begin
      mismatched++;
      $display("FAIL reset_result: got %h, expected 00000000", bus.result);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_ops();
    run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max");
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "mul_max");
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_m1");
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min");
    run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_max");
    run_op(2'b00, 32'd106,       32'd53,        32'd5618,      "mul_small");
    run_op(2'b01, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, "mulh_neg");
    run_op(2'b11, 32'h8000_0000, 32'd4,         32'h0000_0002, "mulhu_pow2");
    run_op(2'b10, 32'd2,         32'h8000_0000, 32'h0000_0001, "mulhsu_uns");
    run_op(2'b01, 32'd2,         32'h8000_0000, 32'hFFFF_FFFF, "mulh_sgn");
  endtask

  task automatic test_zero();
    run_op(2'b00, 32'd0, 32'd12345, 32'd0, "mul_zero_a");
    run_op(2'b11, 32'hDEAD_BEEF, 32'd0, 32'd0, "mulhu_zero_b");
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    bus.fetch   = 1'b1;
    bus.op      = 2'b00;
    bus.factor0 = 32'd3;
    bus.factor1 = 32'd7;
    @(posedge clk);
    #1;
    bus.factor0 = 32'd5;
    lat = 0;
    while (!bus.ready && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    compared++;
    if (lat !== 33) begin
      mismatched++;
      $display("FAIL hold_fetch latency: got %0d edges, expected 33", lat);
    end
    compared++;
    if (bus.result !== 32'd21) begin
      mismatched++;
      $display("FAIL hold_fetch first_result: got %0d, expected 21", bus.result);
    end
    @(posedge clk);
    #1;
    bus.fetch = 1'b0;
    compared++;
    if (bus.ready !== 1'b0) begin
      mismatched++;
      $display("FAIL hold_fetch single_pulse: got %b, expected 0", bus.ready);
    end
    lat = 0;
    while (!bus.ready && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    compared++;
    if (!bus.ready) begin
      mismatched++;
      $display("FAIL hold_fetch second_ready: got timeout, expected pulse");
    end
    compared++;
    if (bus.result !== 32'd35) begin
      mismatched++;
      $display("FAIL hold_fetch second_result: got %0d, expected 35", bus.result);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_abort();
    int pulses;
    @(negedge clk);
    bus.fetch   = 1'b1;
    bus.op      = 2'b00;
    bus.factor0 = 32'd1000;
    bus.factor1 = 32'd1000;
    @(posedge clk);
    #1;
    bus.fetch = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    compared++;
    if (bus.result !== 32'd0) begin
      mismatched++;
      $display("FAIL abort_async_result: got %h, expected 00000000", bus.result);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.ready) pulses++;
    end
    compared++;
    if (pulses !== 0) begin
      mismatched++;
      $display("FAIL abort_no_ready: got %0d pulses, expected 0", pulses);
    end
    compared++;
    if (bus.result !== 32'd0) begin
      mismatched++;
      $display("FAIL abort_result: got %h, expected 00000000", bus.result);
    end
    run_op(2'b00, 32'd21, 32'd3, 32'd63, "after_reset");
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_ops();
    test_zero();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/armleocpu_multiplier.md
ARMLEOCPU_MULTIPLIER -- requirements
Module: armleocpu_multiplier

Interface
REQ-001 The block SHALL have no parameters; the operand width is fixed at 32 bits and the product width at 64 bits.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 fetch  input  1  start request; operands and op are sampled on a rising edge while fetch=1 and the block is idle.
REQ-005 op  input  2  operation select: 00 MUL (low word), 01 MULH (signed x signed, high word), 10 MULHSU (factor0 signed x factor1 unsigned, high word), 11 MULHU (unsigned x unsigned, high word).
REQ-006 factor0  input  32  first operand.
REQ-007 factor1  input  32  second operand.
REQ-008 ready  output  1  one-cycle pulse marking that result is valid.
REQ-009 result  output  32  selected 32-bit result word.

Function
REQ-010 The block SHALL implement three states: IDLE, BUSY, DONE.
REQ-011 In IDLE with fetch=1, the block SHALL latch op, the operand magnitudes, and the product sign, clear the 64-bit accumulator and the 5-bit iteration counter, and enter BUSY.
REQ-012 Magnitude rules: an operand treated as signed SHALL be two's-complement negated when bit 31=1; unsigned operands and MUL operands SHALL be used as-is; 0x80000000 negated SHALL yield unsigned magnitude 2^31.
REQ-013 In BUSY, each cycle SHALL perform one shift-add step: if multiplier bit 0=1, add the 64-bit multiplicand to the accumulator; then shift the multiplicand left 1 and the multiplier right 1.
REQ-014 BUSY SHALL last exactly 32 cycles, counted by the iteration counter, which SHALL wrap from 31 to 0 on the transition to DONE.
REQ-015 On entry to DONE, the 64-bit product SHALL be negated when the latched sign is 1; result SHALL be product[31:0] for MUL and product[63:32] otherwise.
REQ-016 Latency: for fetch accepted at edge N, ready SHALL be 1 for exactly the cycle following edge N+33; on the next edge the block SHALL return to IDLE.
REQ-017 result SHALL hold its value after ready deasserts until the next completion or reset.
REQ-018 fetch asserted during BUSY or DONE SHALL be ignored; no request queueing.
REQ-019 fetch asserted in the cycle immediately after the ready cycle (IDLE) SHALL be accepted normally; back-to-back operations therefore SHALL be issued at a minimum spacing of 34 cycles.
REQ-020 Operand or op changes after acceptance SHALL NOT affect the in-flight result.
REQ-021 A zero operand SHALL NOT shorten latency; the timing SHALL be data-independent.

Reset
REQ-022 While rst_n=0: state IDLE, ready=0, result=0, accumulator and counter 0, regardless of clock.
REQ-023 Reset asserted mid-BUSY or in DONE SHALL abort the operation with no ready pulse; the first fetch after reset release SHALL start a fresh operation.

Verification
REQ-024 op=11, factor0=0xFFFFFFFF, factor1=0xFFFFFFFF -> ready exactly 33 cycles after the fetch edge, result=0xFFFFFFFE; the same operands with op=00 -> result=0x00000001.
REQ-025 op=01, factor0=0xFFFFFFFF, factor1=0xFFFFFFFF (-1 x -1) -> result=0x00000000; op=01, factor0=0x80000000, factor1=0x80000000 -> result=0x40000000.
REQ-026 op=10, factor0=0xFFFFFFFF, factor1=0xFFFFFFFF -> result=0xFFFFFFFF; op=00, factor0=106, factor1=53 -> result=5618 (0x15F2).
REQ-027 Accept op=00, factor0=3, factor1=7; hold fetch=1 with factor0=5 through BUSY -> a single ready pulse with result=21, and the second request is not taken until IDLE.
REQ-028 Pulse rst_n low 10 cycles into an operation -> no ready pulse, result=0; then op=00, factor0=21, factor1=3 -> result=63 with nominal latency.
